// File: rtl/mem_arbiter_if.sv
// Bundles the instruction-side, data-side and memory-side buses of mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the CPU and memory view.
interface mem_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  logic                 i_readM;
  logic [WORD_SIZE-1:0] i_address;
  logic [WORD_SIZE-1:0] i_rdata;
  logic                 i_ready;

  logic                 d_readM;
  logic                 d_writeM;
  logic [WORD_SIZE-1:0] d_address;
  logic [WORD_SIZE-1:0] d_wdata;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 d_ready;

  logic                 m_readM;
  logic                 m_writeM;
  logic [WORD_SIZE-1:0] m_address;
  logic [WORD_SIZE-1:0] m_wdata;
  logic [WORD_SIZE-1:0] m_rdata;

  modport slave (
    input  i_readM, i_address, d_readM, d_writeM, d_address, d_wdata, m_rdata,
    output i_rdata, i_ready, d_rdata, d_ready, m_readM, m_writeM, m_address, m_wdata
  );

  modport master (
    output i_readM, i_address, d_readM, d_writeM, d_address, d_wdata, m_rdata,
    input  i_rdata, i_ready, d_rdata, d_ready, m_readM, m_writeM, m_address, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory port between I-fetch and D sides; one access per LATENCY+2 cycles, ready LATENCY+1 after grant.
// Requests are held levels ignored while busy; ARB_ROUND_ROBIN_EN alternates grants on contention, else D beats I.
module mem_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int LATENCY   = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_arbiter_if.slave   bus,
  output logic           busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  logic [1:0]           state;
  logic [7:0]           cnt;
  logic                 gnt_d;
  logic                 is_wr;
  logic                 last_grant;
  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [WORD_SIZE-1:0] i_rdata_q;
  logic [WORD_SIZE-1:0] d_rdata_q;

  logic d_req;
  logic i_req;
  logic pick_d;

  assign d_req = bus.d_readM | bus.d_writeM;
  assign i_req = bus.i_readM;

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant: 1 = D side. On contention the side that did not win last time goes.
  assign pick_d = d_req & (~i_req | ~last_grant);
`else
  assign pick_d = d_req;
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= 8'd0;
      gnt_d      <= 1'b0;
      is_wr      <= 1'b0;
      last_grant <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (d_req | i_req) begin
            gnt_d      <= pick_d;
            last_grant <= pick_d;
            is_wr      <= pick_d & bus.d_writeM;
            addr_q     <= pick_d ? bus.d_address : bus.i_address;
            if (pick_d & bus.d_writeM) begin
              wdata_q <= bus.d_wdata;
            end
            cnt   <= CNT_INIT;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt == 8'd0) begin
            // m_rdata is only guaranteed valid in the final strobe cycle.
            if (!is_wr) begin
              if (gnt_d) begin
                d_rdata_q <= bus.m_rdata;
              end else begin
                i_rdata_q <= bus.m_rdata;
              end
            end
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.m_readM   = (state == ST_BUSY) & ~is_wr;
  assign bus.m_writeM  = (state == ST_BUSY) & is_wr;
  assign bus.m_address = addr_q;
  assign bus.m_wdata   = wdata_q;
  assign bus.i_ready   = (state == ST_DONE) & ~gnt_d;
  assign bus.d_ready   = (state == ST_DONE) & gnt_d;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus randomized requesters,
// all cycles compared against a transaction-level model of the arbiter and memory.
module tb_mem_arbiter;
  localparam int W = 16;
  localparam int L = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy;

  mem_arbiter_if #(.WORD_SIZE(W)) bus ();

  mem_arbiter #(.WORD_SIZE(W), .LATENCY(L)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
    end
  endtask

  // Memory contents before any write: a few pinned words, a hash elsewhere.
  function automatic logic [15:0] init_val(input logic [9:0] a);
    case (a)
      10'h010: return 16'h1234;
      10'h020: return 16'h7777;
      10'h100: return 16'hC0DE;
      10'h300: return 16'h5A5A;
      default: return {6'h2B, a} ^ 16'h9E37;
    endcase
  endfunction

  // Memory model seen by the DUT.
  bit [15:0] mem_w [1024];
  bit        mem_v [1024];
  always @(posedge clk) begin
    if (bus.m_writeM) begin
      mem_w[bus.m_address[9:0]] <= bus.m_wdata;
      mem_v[bus.m_address[9:0]] <= 1'b1;
    end
  end
  assign bus.m_rdata = !bus.m_readM ? 16'h0 :
                       (mem_v[bus.m_address[9:0]] ? mem_w[bus.m_address[9:0]] : init_val(bus.m_address[9:0]));

  // Reference model: one outstanding transaction, tracked by its age in cycles since grant.
  bit        act;
  int        age;
  bit        g_d, g_wr, last_d;
  logic [15:0] g_addr, g_wdata, exp_i_rdata, exp_d_rdata;
  bit [15:0] ref_w [1024];
  bit        ref_v [1024];
  logic      m_dreq, m_pick_d;

  function automatic logic [15:0] ref_rd(input logic [9:0] a);
    return ref_v[a] ? ref_w[a] : init_val(a);
  endfunction

  always_comb begin
    m_dreq = bus.d_readM || bus.d_writeM;
`ifdef ARB_ROUND_ROBIN_EN
    m_pick_d = (m_dreq && bus.i_readM) ? !last_d : m_dreq;
`else
    m_pick_d = m_dreq;
`endif
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act <= 1'b0;
      age <= 0;
      g_d <= 1'b0;
      g_wr <= 1'b0;
      last_d <= 1'b0;
      g_addr <= '0;
      g_wdata <= '0;
      exp_i_rdata <= '0;
      exp_d_rdata <= '0;
    end else if (!act) begin
      if (m_dreq || bus.i_readM) begin
        act     <= 1'b1;
        age     <= 0;
        g_d     <= m_pick_d;
        last_d  <= m_pick_d;
        g_wr    <= m_pick_d && bus.d_writeM;
        g_addr  <= m_pick_d ? bus.d_address : bus.i_address;
        g_wdata <= bus.d_wdata;
      end
    end else begin
      age <= age + 1;
      if (age == L - 1) begin
        if (g_wr) begin
          ref_w[g_addr[9:0]] <= g_wdata;
          ref_v[g_addr[9:0]] <= 1'b1;
        end else if (g_d) begin
          exp_d_rdata <= ref_rd(g_addr[9:0]);
        end else begin
          exp_i_rdata <= ref_rd(g_addr[9:0]);
        end
      end
      if (age == L) act <= 1'b0;
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", busy, act);
      chk("m_readM", bus.m_readM, act && age < L && !g_wr);
      chk("m_writeM", bus.m_writeM, act && age < L && g_wr);
      chk("i_ready", bus.i_ready, act && age == L && !g_d);
      chk("d_ready", bus.d_ready, act && age == L && g_d);
      chk("i_rdata", bus.i_rdata, exp_i_rdata);
      chk("d_rdata", bus.d_rdata, exp_d_rdata);
      if (act && age < L) chk("m_address", bus.m_address, g_addr);
      if (act && age < L && g_wr) chk("m_wdata", bus.m_wdata, g_wdata);
      if (!reset_n) begin
        chk("rst_m_address", bus.m_address, 16'h0);
        chk("rst_m_wdata", bus.m_wdata, 16'h0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errs, checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_rdy(input bit d_side, input int lim, output int n);
    n = 0;
    while (!(d_side ? bus.d_ready : bus.i_ready) && n < lim) begin
      tick();
      n++;
    end
    chk(d_side ? "d_ready_timeout" : "i_ready_timeout", n < lim, 1);
  endtask

  initial begin
    int n;
    bit order [$];
    bit exp_order [4];
    int r;

    bus.i_readM = 0; bus.i_address = '0;
    bus.d_readM = 0; bus.d_writeM = 0; bus.d_address = '0; bus.d_wdata = '0;
    reset_n = 0;
    cmp_en = 1;

    // Reset held with requests asserted.
    bus.i_readM = 1; bus.i_address = 16'h0020;
    bus.d_readM = 1; bus.d_address = 16'h0100;
    repeat (3) begin
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_m_readM", bus.m_readM, 0);
      chk("rst_d_ready", bus.d_ready, 0);
      chk("rst_i_rdata", bus.i_rdata, 0);
    end
    reset_n = 1;
    tick();
    chk("first_grant_busy", busy, 1);
    chk("first_grant_addr", bus.m_address, 16'h0100);
    wait_rdy(1, 10, n);
    chk("first_d_rdata", bus.d_rdata, 16'hC0DE);
    bus.d_readM = 0;
    wait_rdy(0, 10, n);
    chk("first_i_rdata", bus.i_rdata, 16'h7777);
    bus.i_readM = 0;
    tick();

    // Single I read.
    bus.i_readM = 1; bus.i_address = 16'h0010;
    tick();
    chk("ird_k1_rd", bus.m_readM, 1);
    chk("ird_k1_addr", bus.m_address, 16'h0010);
    tick();
    chk("ird_k2_rd", bus.m_readM, 1);
    chk("ird_k2_addr", bus.m_address, 16'h0010);
    tick();
    chk("ird_ready", bus.i_ready, 1);
    chk("ird_d_ready", bus.d_ready, 0);
    chk("ird_rdata", bus.i_rdata, 16'h1234);
    chk("ird_done_rd", bus.m_readM, 0);
    bus.i_readM = 0;
    tick();
    chk("ird_pulse_1cyc", bus.i_ready, 0);

    // Simultaneous I and D reads.
    bus.i_readM = 1; bus.i_address = 16'h0020;
    bus.d_readM = 1; bus.d_address = 16'h0100;
    wait_rdy(1, 10, n);
    chk("both_d_ready_cycle", n, 3);
    chk("both_d_rdata", bus.d_rdata, 16'hC0DE);
    bus.d_readM = 0;
    wait_rdy(0, 10, n);
    chk("both_i_after_d", n, 4);
    chk("both_i_rdata", bus.i_rdata, 16'h7777);
    bus.i_readM = 0;
    tick();

    // Prime d_rdata, then a write with read also asserted.
    bus.d_readM = 1; bus.d_address = 16'h0300;
    wait_rdy(1, 10, n);
    chk("prime_d_rdata", bus.d_rdata, 16'h5A5A);
    bus.d_readM = 0;
    tick();
    bus.d_readM = 1; bus.d_writeM = 1; bus.d_address = 16'h0200; bus.d_wdata = 16'hBEEF;
    tick();
    chk("wr_k1_wr", bus.m_writeM, 1);
    chk("wr_k1_rd", bus.m_readM, 0);
    chk("wr_k1_wdata", bus.m_wdata, 16'hBEEF);
    chk("wr_k1_addr", bus.m_address, 16'h0200);
    bus.d_address = 16'h0FFF;
    tick();
    chk("wr_k2_wr", bus.m_writeM, 1);
    chk("wr_k2_addr_held", bus.m_address, 16'h0200);
    tick();
    chk("wr_ready", bus.d_ready, 1);
    chk("wr_keeps_d_rdata", bus.d_rdata, 16'h5A5A);
    bus.d_readM = 0; bus.d_writeM = 0;
    tick();
    bus.d_readM = 1; bus.d_address = 16'h0200;
    wait_rdy(1, 10, n);
    chk("wr_readback", bus.d_rdata, 16'hBEEF);
    bus.d_readM = 0;
    tick();

    // Reset in the first BUSY cycle of a read.
    bus.i_readM = 1; bus.i_address = 16'h0020;
    tick();
    chk("abort_pre_rd", bus.m_readM, 1);
    reset_n = 0;
    #1;
    chk("abort_rd_drop", bus.m_readM, 0);
    chk("abort_busy", busy, 0);
    bus.i_readM = 0;
    repeat (3) begin
      tick();
      chk("abort_no_ready", bus.i_ready, 0);
    end
    reset_n = 1;
    tick();
    chk("abort_idle", busy, 0);

    // Both sides held continuously for four accesses.
    bus.i_readM = 1; bus.i_address = 16'h0010;
    bus.d_readM = 1; bus.d_address = 16'h0100;
    n = 0;
    while (order.size() < 4 && n < 40) begin
      tick();
      n++;
      if (bus.i_ready) order.push_back(1'b0);
      if (bus.d_ready) order.push_back(1'b1);
    end
    chk("hold4_timeout", order.size(), 4);
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int k = 0; k < 4; k++) begin
      if (k < order.size()) chk($sformatf("hold4_grant%0d", k), order[k], exp_order[k]);
    end
    bus.i_readM = 0; bus.d_readM = 0;
    tick();

    // Randomized requesters, checked by the model each cycle.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (bus.i_readM) begin
        if (bus.i_ready) begin
          bus.i_readM = ($urandom_range(0, 1) == 0);
          bus.i_address = 16'($urandom);
        end
      end else if ($urandom_range(0, 3) == 0) begin
        bus.i_readM = 1;
        bus.i_address = 16'($urandom);
      end
      if (bus.d_readM || bus.d_writeM) begin
        if (bus.d_ready) begin
          if ($urandom_range(0, 1) == 0) begin
            bus.d_readM = 0; bus.d_writeM = 0;
          end else begin
            r = $urandom_range(0, 2);
            bus.d_readM = (r != 1); bus.d_writeM = (r != 0);
            bus.d_address = 16'($urandom); bus.d_wdata = 16'($urandom);
          end
        end
      end else if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 2);
        bus.d_readM = (r != 1); bus.d_writeM = (r != 0);
        bus.d_address = 16'($urandom); bus.d_wdata = 16'($urandom);
      end
    end
    bus.i_readM = 0; bus.d_readM = 0; bus.d_writeM = 0;
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
